// File: rtl/cv32e40p_avfs_pkg.sv
// Shared types for the FPU-domain AVFS governor: FSM encoding, register map, STATUS layout.
package cv32e40p_avfs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MONITOR = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_SWITCH  = 3'd3,
    ST_SETTLE  = 3'd4
  } avfs_state_e;

  localparam logic [7:0] REG_CTRL    = 8'h00;
  localparam logic [7:0] REG_WINDOW  = 8'h04;
  localparam logic [7:0] REG_HI_THR  = 8'h08;
  localparam logic [7:0] REG_LO_THR  = 8'h0C;
  localparam logic [7:0] REG_MAN_DIV = 8'h10;
  localparam logic [7:0] REG_STATUS  = 8'h14;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_MANUAL_BIT = 1;
  localparam int LAST_CNT_W      = 12;

  // STATUS = {state[18:16], freq_sel[15:12], last_cnt[11:0]}
  function automatic logic [31:0] pack_status(input avfs_state_e st, input logic [3:0] freq,
                                              input logic [LAST_CNT_W-1:0] last);
    logic [31:0] s;
    s         = '0;
    s[18:16]  = st;
    s[15:12]  = freq;
    s[11:0]   = last;
    return s;
  endfunction

endpackage

// File: rtl/cv32e40p_avfs_window_cnt.sv
// Observation window and saturating activity counter; window_end/act_total are combinational
// in the last window cycle, last_cnt updates on the closing edge. Counters sit at zero while !run.
module cv32e40p_avfs_window_cnt
  import cv32e40p_avfs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  activity,
  input  logic [CNT_W-1:0]      window_len,
  output logic                  window_end,
  output logic [CNT_W-1:0]      act_total,
  output logic [LAST_CNT_W-1:0] last_cnt
);

  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] act_cnt;
  logic [CNT_W-1:0] win_last;

  // A zero-length window behaves as a one-cycle window; >= tolerates WINDOW shrinking mid-window.
  assign win_last   = (window_len == '0) ? '0 : window_len - CNT_W'(1);
  assign window_end = run && (win_cnt >= win_last);
  assign act_total  = (act_cnt == '1) ? act_cnt : act_cnt + CNT_W'(activity);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      act_cnt  <= '0;
      last_cnt <= '0;
    end else if (!run) begin
      win_cnt <= '0;
      act_cnt <= '0;
    end else if (window_end) begin
      win_cnt  <= '0;
      act_cnt  <= '0;
      last_cnt <= act_total[LAST_CNT_W-1:0];
    end else begin
      win_cnt <= win_cnt + CNT_W'(1);
      act_cnt <= act_total;
    end
  end

endmodule

// File: rtl/cv32e40p_avfs_governor.sv
// FPU clock-ratio governor: register file, ratio step/clamp and the drain/switch/settle FSM.
// Ratio changes hold new APU requests until the FPU is idle; freq_sel_o moves only in SWITCH.
module cv32e40p_avfs_governor
  import cv32e40p_avfs_pkg::*;
#(
  parameter int DIV_W      = 4,
  parameter int MAX_DIV    = 8,
  parameter int CNT_W      = 16,
  parameter int DEF_WINDOW = 256,
  parameter int DEF_HI_THR = 192,
  parameter int DEF_LO_THR = 32,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             activity_i,
  input  logic             apu_busy_i,
  input  logic             apb_sel_i,
  input  logic             apb_we_i,
  input  logic [7:0]       apb_addr_i,
  input  logic [31:0]      apb_wdata_i,
  output logic [31:0]      apb_rdata_o,
  output logic [DIV_W-1:0] freq_sel_o,
  output logic             apu_hold_o,
  output logic             switching_o
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  avfs_state_e            state_q, state_d;
  logic [DIV_W-1:0]       freq_q, freq_d, target_q, target_d, auto_target, man_clamped;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   en_q, manual_q;
  logic [CNT_W-1:0]       window_q, hi_thr_q, lo_thr_q;
  logic [DIV_W-1:0]       man_div_q;
  logic                   wr, man_wr, window_end;
  logic [CNT_W-1:0]       act_total;
  logic [LAST_CNT_W-1:0]  last_cnt;

  assign wr     = apb_sel_i && apb_we_i;
  assign man_wr = wr && (apb_addr_i == REG_MAN_DIV);

  always_comb begin
    if (apb_wdata_i == '0)                 man_clamped = DIV_W'(1);
    else if (apb_wdata_i > 32'(MAX_DIV))   man_clamped = DIV_W'(MAX_DIV);
    else                                   man_clamped = apb_wdata_i[DIV_W-1:0];
  end

  // Speed-up (smaller ratio) wins when both thresholds are met.
  always_comb begin
    if (act_total >= hi_thr_q && freq_q > DIV_W'(1))
      auto_target = freq_q - DIV_W'(1);
    else if (act_total <= lo_thr_q && freq_q < DIV_W'(MAX_DIV))
      auto_target = freq_q + DIV_W'(1);
    else
      auto_target = freq_q;
  end

  cv32e40p_avfs_window_cnt #(.CNT_W(CNT_W)) u_window_cnt (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .run        (state_q == ST_MONITOR),
    .activity   (activity_i),
    .window_len (window_q),
    .window_end (window_end),
    .act_total  (act_total),
    .last_cnt   (last_cnt)
  );

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    freq_d   = freq_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: if (en_q) state_d = ST_MONITOR;
      ST_MONITOR: begin
        if (!en_q) begin
          if (freq_q == DIV_W'(1)) state_d = ST_IDLE;
          else begin
            target_d = DIV_W'(1);
            state_d  = ST_DRAIN;
          end
        end else if (man_wr && man_clamped != freq_q) begin
          target_d = man_clamped;
          state_d  = ST_DRAIN;
        end else if (window_end && !manual_q && auto_target != freq_q) begin
          target_d = auto_target;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!apu_busy_i) state_d = ST_SWITCH;
      ST_SWITCH: begin
        if (apu_busy_i) state_d = ST_DRAIN;
        else begin
          freq_d   = target_q;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          if (en_q)                     state_d = ST_MONITOR;
          else if (freq_q == DIV_W'(1)) state_d = ST_IDLE;
          else begin
            // Disabled mid-sequence at a ratio other than 1: walk back to full speed.
            target_d = DIV_W'(1);
            state_d  = ST_DRAIN;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      freq_q   <= DIV_W'(1);
      target_q <= DIV_W'(1);
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      freq_q   <= freq_d;
      target_q <= target_d;
      settle_q <= settle_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q      <= 1'b0;
      manual_q  <= 1'b0;
      window_q  <= CNT_W'(DEF_WINDOW);
      hi_thr_q  <= CNT_W'(DEF_HI_THR);
      lo_thr_q  <= CNT_W'(DEF_LO_THR);
      man_div_q <= DIV_W'(1);
    end else if (wr) begin
      case (apb_addr_i)
        REG_CTRL: begin
          en_q     <= apb_wdata_i[CTRL_EN_BIT];
          manual_q <= apb_wdata_i[CTRL_MANUAL_BIT];
        end
        REG_WINDOW:  window_q  <= apb_wdata_i[CNT_W-1:0];
        REG_HI_THR:  hi_thr_q  <= apb_wdata_i[CNT_W-1:0];
        REG_LO_THR:  lo_thr_q  <= apb_wdata_i[CNT_W-1:0];
        REG_MAN_DIV: man_div_q <= man_clamped;
        default: ;
      endcase
    end
  end

  always_comb begin
    apb_rdata_o = '0;
    if (apb_sel_i && !apb_we_i) begin
      case (apb_addr_i)
        REG_CTRL:    apb_rdata_o = {30'd0, manual_q, en_q};
        REG_WINDOW:  apb_rdata_o = 32'(window_q);
        REG_HI_THR:  apb_rdata_o = 32'(hi_thr_q);
        REG_LO_THR:  apb_rdata_o = 32'(lo_thr_q);
        REG_MAN_DIV: apb_rdata_o = 32'(man_div_q);
        REG_STATUS:  apb_rdata_o = pack_status(state_q, 4'(freq_q), last_cnt);
        default:     apb_rdata_o = '0;
      endcase
    end
  end

  assign freq_sel_o  = freq_q;
  assign apu_hold_o  = (state_q == ST_DRAIN) || (state_q == ST_SWITCH) || (state_q == ST_SETTLE);
  assign switching_o = apu_hold_o;

endmodule
